// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter: write-back pipe vs. buffered long-latency results.
// Keeps write-after-write order, bounds head starvation, and exposes a pending-write lookup.
module rf_wport_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_DEFER  = 3
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              pipe_valid_i,
    input  logic                              pipe_we_i,
    input  logic [4:0]                        pipe_addr_i,
    input  logic [31:0]                       pipe_data_i,
    output logic                              pipe_stall_o,
    input  logic                              lu_valid_i,
    input  logic [4:0]                        lu_addr_i,
    input  logic [31:0]                       lu_data_i,
    output logic                              lu_ready_o,
    output logic                              rf_we_o,
    output logic [4:0]                        rf_addr_o,
    output logic [31:0]                       rf_data_o,
    input  logic [4:0]                        chk_addr_i,
    output logic                              chk_hit_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_o
);

    localparam int unsigned AW  = 5;
    localparam int unsigned DW  = 32;
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DFW = $clog2(MAX_DEFER + 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t [FIFO_DEPTH-1:0] ent_q, ent_d;
    logic   [FIFO_DEPTH-1:0] vld_q, vld_d;
    logic   [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic   [CW-1:0]         count_q, count_d;
    logic   [DFW-1:0]        defer_q, defer_d;

    logic   p_req, empty, full, waw_match, chk_match, waw_blk;
    logic   lu_acc, lu_nz, wr_head, wr_pipe, bypass, enq;
    entry_t head_ent;

    // Request decode, hazard lookup and write-port grant
    always_comb begin
        p_req     = pipe_valid_i && pipe_we_i && (pipe_addr_i != '0);
        empty     = (count_q == '0);
        full      = (count_q == CW'(FIFO_DEPTH));
        head_ent  = ent_q[head_q];
        waw_match = 1'b0;
        chk_match = 1'b0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (vld_q[i] && (ent_q[i].addr == pipe_addr_i)) waw_match = 1'b1;
            if (vld_q[i] && (ent_q[i].addr == chk_addr_i))  chk_match = 1'b1;
        end
        waw_blk    = p_req && waw_match;
        lu_ready_o = !full && !rst_i;
        lu_acc     = lu_valid_i && lu_ready_o;
        lu_nz      = lu_acc && (lu_addr_i != '0);

        wr_head = 1'b0;
        wr_pipe = 1'b0;
        bypass  = 1'b0;
        if (!rst_i) begin
            if (!empty && ((defer_q == DFW'(MAX_DEFER)) || waw_blk)) wr_head = 1'b1;
            else if (p_req && !waw_blk)                                wr_pipe = 1'b1;
            else if (!empty)                                           wr_head = 1'b1;
            else if (lu_nz)                                            bypass  = 1'b1;
        end

        rf_we_o = wr_head || wr_pipe || bypass;
        if (wr_head) begin
            rf_addr_o = head_ent.addr;
            rf_data_o = head_ent.data;
        end else if (wr_pipe) begin
            rf_addr_o = pipe_addr_i;
            rf_data_o = pipe_data_i;
        end else begin
            rf_addr_o = lu_addr_i;
            rf_data_o = lu_data_i;
        end
        pipe_stall_o = !rst_i && p_req && !wr_pipe;
        chk_hit_o    = !rst_i && (chk_addr_i != '0) && chk_match;
        pending_o    = count_q;
    end

    // FIFO pointer, occupancy and defer-counter next state
    always_comb begin
        ent_d   = ent_q;
        vld_d   = vld_q;
        head_d  = head_q;
        tail_d  = tail_q;
        enq     = lu_nz && !bypass;
        if (enq) begin
            ent_d[tail_q] = '{addr: lu_addr_i, data: lu_data_i};
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + PW'(1);
        end
        if (wr_head) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
        count_d = count_q + CW'(enq) - CW'(wr_head);
        if (empty || wr_head)               defer_d = '0;
        else if (defer_q != DFW'(MAX_DEFER)) defer_d = defer_q + DFW'(1);
        else                                 defer_d = defer_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            defer_q <= '0;
        end else begin
            vld_q   <= vld_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            defer_q <= defer_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by vld_q
    always_ff @(posedge clk_i) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scoreboard bench for rf_wport_arbiter: per-cycle stimulus tables, expected writes queued
// at drive time and popped when the register-file port is sampled.
module tb_rf_wport_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        pipe_valid_i, pipe_we_i;
    logic [4:0]  pipe_addr_i;
    logic [31:0] pipe_data_i;
    logic        pipe_stall_o;
    logic        lu_valid_i;
    logic [4:0]  lu_addr_i;
    logic [31:0] lu_data_i;
    logic        lu_ready_o;
    logic        rf_we_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;
    logic [4:0]  chk_addr_i;
    logic        chk_hit_o;
    logic [1:0]  pending_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        pv;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic        rd;
        int          pn;
        logic [4:0]  ck;
        logic        ht;
    } cyc_t;

    logic [36:0] exp_q[$];
    logic [36:0] exp_w;
    logic [31:0] shadow[32];

    rf_wport_arbiter #(.FIFO_DEPTH(2), .MAX_DEFER(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pipe_valid_i(pipe_valid_i), .pipe_we_i(pipe_we_i),
        .pipe_addr_i(pipe_addr_i), .pipe_data_i(pipe_data_i), .pipe_stall_o(pipe_stall_o),
        .lu_valid_i(lu_valid_i), .lu_addr_i(lu_addr_i), .lu_data_i(lu_data_i),
        .lu_ready_o(lu_ready_o),
        .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o),
        .chk_addr_i(chk_addr_i), .chk_hit_o(chk_hit_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    // Register file contents as seen through the write port
    always @(negedge clk_i) begin
        if (rf_we_o === 1'b1) shadow[rf_addr_o] = rf_data_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    function automatic cyc_t mk(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic st, input logic rd, input int pn,
                                input logic [4:0] ck, input logic ht);
        cyc_t c;
        c.pv = pv; c.pa = pa; c.pd = pd; c.lv = lv; c.la = la; c.ld = ld;
        c.we = we; c.wa = wa; c.wd = wd; c.st = st; c.rd = rd; c.pn = pn;
        c.ck = ck; c.ht = ht;
        return c;
    endfunction

    task automatic apply(input cyc_t c);
        @(posedge clk_i); #1;
        pipe_valid_i = c.pv;
        pipe_we_i    = c.pv;
        pipe_addr_i  = c.pa;
        pipe_data_i  = c.pd;
        lu_valid_i   = c.lv;
        lu_addr_i    = c.la;
        lu_data_i    = c.ld;
        chk_addr_i   = c.ck;
        if (c.we) exp_q.push_back({c.wa, c.wd});
    endtask

    task automatic test_reset();
        rst_i = 1'b1; pipe_valid_i = 1'b1; pipe_we_i = 1'b1; pipe_addr_i = 5'd4;
        pipe_data_i = 32'h4; lu_valid_i = 1'b1; lu_addr_i = 5'd3; lu_data_i = 32'h33;
        chk_addr_i = 5'd3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_i);
            n_chk++; if (lu_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, lu_ready_o); end
            n_chk++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we[%0d]: got %b expected 0", k, rf_we_o); end
            n_chk++; if (pipe_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall[%0d]: got %b expected 0", k, pipe_stall_o); end
            n_chk++; if (chk_hit_o !== 1'b0) begin n_fail++; $display("FAIL reset_hit[%0d]: got %b expected 0", k, chk_hit_o); end
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0; pipe_valid_i = 1'b0; pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        @(negedge clk_i);
        n_chk++; if (pending_o !== 2'd0) begin n_fail++; $display("FAIL reset_pending: got %0d expected 0", pending_o); end
        n_chk++; if (lu_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", lu_ready_o); end
    endtask

    task automatic test_bypass();
        cyc_t t[$];
        t.push_back(mk(0, 0, 0, 1, 5, 32'hDEAD, 1, 5, 32'hDEAD, 0, 1, 0, 0, 0));
        t.push_back(mk(0, 0, 0, 0, 0, 0,        0, 0, 0,        0, 1, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk_i);
            if (t[i].we) begin
                exp_w = exp_q.pop_front();
                n_chk++; if (rf_we_o !== 1'b1 || {rf_addr_o, rf_data_o} !== exp_w) begin n_fail++; $display("FAIL bypass_write[%0d]: got we=%b x%0d=%h expected x%0d=%h", i, rf_we_o, rf_addr_o, rf_data_o, exp_w[36:32], exp_w[31:0]); end
            end else begin
                n_chk++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL bypass_we[%0d]: got %b expected 0", i, rf_we_o); end
            end
            n_chk++; if (pipe_stall_o !== t[i].st) begin n_fail++; $display("FAIL bypass_stall[%0d]: got %b expected %b", i, pipe_stall_o, t[i].st); end
            n_chk++; if (lu_ready_o !== t[i].rd) begin n_fail++; $display("FAIL bypass_ready[%0d]: got %b expected %b", i, lu_ready_o, t[i].rd); end
            n_chk++; if (pending_o !== 2'(t[i].pn)) begin n_fail++; $display("FAIL bypass_pending[%0d]: got %0d expected %0d", i, pending_o, t[i].pn); end
        end
    endtask

    task automatic test_starvation();
        cyc_t t[$];
        t.push_back(mk(1, 1, 32'h101, 1, 7, 32'h11, 1, 1, 32'h101, 0, 1, 0, 7, 0));
        t.push_back(mk(1, 2, 32'h102, 0, 0, 0,      1, 2, 32'h102, 0, 1, 1, 7, 1));
        t.push_back(mk(1, 3, 32'h103, 0, 0, 0,      1, 3, 32'h103, 0, 1, 1, 7, 1));
        t.push_back(mk(1, 4, 32'h104, 0, 0, 0,      1, 4, 32'h104, 0, 1, 1, 7, 1));
        t.push_back(mk(1, 5, 32'h105, 0, 0, 0,      1, 7, 32'h11,  1, 1, 1, 7, 1));
        t.push_back(mk(1, 5, 32'h105, 0, 0, 0,      1, 5, 32'h105, 0, 1, 0, 7, 0));
        t.push_back(mk(0, 0, 0,       0, 0, 0,      0, 0, 0,       0, 1, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk_i);
            if (t[i].we) begin
                exp_w = exp_q.pop_front();
                n_chk++; if (rf_we_o !== 1'b1 || {rf_addr_o, rf_data_o} !== exp_w) begin n_fail++; $display("FAIL starve_write[%0d]: got we=%b x%0d=%h expected x%0d=%h", i, rf_we_o, rf_addr_o, rf_data_o, exp_w[36:32], exp_w[31:0]); end
            end else begin
                n_chk++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL starve_we[%0d]: got %b expected 0", i, rf_we_o); end
            end
            n_chk++; if (pipe_stall_o !== t[i].st) begin n_fail++; $display("FAIL starve_stall[%0d]: got %b expected %b", i, pipe_stall_o, t[i].st); end
            n_chk++; if (pending_o !== 2'(t[i].pn)) begin n_fail++; $display("FAIL starve_pending[%0d]: got %0d expected %0d", i, pending_o, t[i].pn); end
            n_chk++; if (chk_hit_o !== t[i].ht) begin n_fail++; $display("FAIL starve_hit[%0d]: got %b expected %b", i, chk_hit_o, t[i].ht); end
        end
    endtask

    task automatic test_waw();
        cyc_t t[$];
        t.push_back(mk(1, 2, 32'h22, 1, 9, 32'hA, 1, 2, 32'h22, 0, 1, 0, 9, 0));
        t.push_back(mk(1, 9, 32'hB,  0, 0, 0,     1, 9, 32'hA,  1, 1, 1, 9, 1));
        t.push_back(mk(1, 9, 32'hB,  0, 0, 0,     1, 9, 32'hB,  0, 1, 0, 9, 0));
        t.push_back(mk(0, 0, 0,      0, 0, 0,     0, 0, 0,      0, 1, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk_i);
            if (t[i].we) begin
                exp_w = exp_q.pop_front();
                n_chk++; if (rf_we_o !== 1'b1 || {rf_addr_o, rf_data_o} !== exp_w) begin n_fail++; $display("FAIL waw_write[%0d]: got we=%b x%0d=%h expected x%0d=%h", i, rf_we_o, rf_addr_o, rf_data_o, exp_w[36:32], exp_w[31:0]); end
            end else begin
                n_chk++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL waw_we[%0d]: got %b expected 0", i, rf_we_o); end
            end
            n_chk++; if (pipe_stall_o !== t[i].st) begin n_fail++; $display("FAIL waw_stall[%0d]: got %b expected %b", i, pipe_stall_o, t[i].st); end
            n_chk++; if (pending_o !== 2'(t[i].pn)) begin n_fail++; $display("FAIL waw_pending[%0d]: got %0d expected %0d", i, pending_o, t[i].pn); end
            n_chk++; if (chk_hit_o !== t[i].ht) begin n_fail++; $display("FAIL waw_hit[%0d]: got %b expected %b", i, chk_hit_o, t[i].ht); end
        end
        n_chk++; if (shadow[9] !== 32'hB) begin n_fail++; $display("FAIL waw_final_x9: got %h expected 0000000b", shadow[9]); end
    endtask

    task automatic test_full();
        cyc_t t[$];
        t.push_back(mk(1, 3,  1, 1, 10, 32'hA0, 1, 3,  1,      0, 1, 0, 10, 0));
        t.push_back(mk(1, 4,  2, 1, 11, 32'hB0, 1, 4,  2,      0, 1, 1, 10, 1));
        t.push_back(mk(1, 5,  3, 1, 12, 32'hC0, 1, 5,  3,      0, 0, 2, 11, 1));
        t.push_back(mk(1, 6,  4, 1, 12, 32'hC0, 1, 6,  4,      0, 0, 2, 0,  0));
        t.push_back(mk(1, 13, 5, 1, 12, 32'hC0, 1, 10, 32'hA0, 1, 0, 2, 12, 0));
        t.push_back(mk(1, 13, 5, 1, 12, 32'hC0, 1, 13, 5,      0, 1, 1, 10, 0));
        t.push_back(mk(0, 0,  0, 0, 0,  0,      1, 11, 32'hB0, 0, 0, 2, 12, 1));
        t.push_back(mk(0, 0,  0, 0, 0,  0,      1, 12, 32'hC0, 0, 1, 1, 12, 1));
        t.push_back(mk(0, 0,  0, 0, 0,  0,      0, 0,  0,      0, 1, 0, 12, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk_i);
            if (t[i].we) begin
                exp_w = exp_q.pop_front();
                n_chk++; if (rf_we_o !== 1'b1 || {rf_addr_o, rf_data_o} !== exp_w) begin n_fail++; $display("FAIL full_write[%0d]: got we=%b x%0d=%h expected x%0d=%h", i, rf_we_o, rf_addr_o, rf_data_o, exp_w[36:32], exp_w[31:0]); end
            end else begin
                n_chk++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL full_we[%0d]: got %b expected 0", i, rf_we_o); end
            end
            n_chk++; if (pipe_stall_o !== t[i].st) begin n_fail++; $display("FAIL full_stall[%0d]: got %b expected %b", i, pipe_stall_o, t[i].st); end
            n_chk++; if (lu_ready_o !== t[i].rd) begin n_fail++; $display("FAIL full_ready[%0d]: got %b expected %b", i, lu_ready_o, t[i].rd); end
            n_chk++; if (pending_o !== 2'(t[i].pn)) begin n_fail++; $display("FAIL full_pending[%0d]: got %0d expected %0d", i, pending_o, t[i].pn); end
            n_chk++; if (chk_hit_o !== t[i].ht) begin n_fail++; $display("FAIL full_hit[%0d]: got %b expected %b", i, chk_hit_o, t[i].ht); end
        end
    endtask

    task automatic test_x0();
        cyc_t t[$];
        t.push_back(mk(0, 0, 0,     1, 0, 32'h55, 0, 0, 0,     0, 1, 0, 0, 0));
        t.push_back(mk(1, 0, 32'h77, 0, 0, 0,     0, 0, 0,     0, 1, 0, 0, 0));
        t.push_back(mk(1, 1, 32'h1,  1, 8, 32'h88, 1, 1, 32'h1,  0, 1, 0, 8, 0));
        t.push_back(mk(0, 0, 0,     1, 0, 32'h55, 1, 8, 32'h88, 0, 1, 1, 8, 1));
        t.push_back(mk(1, 0, 32'h66, 0, 0, 0,     0, 0, 0,     0, 1, 0, 0, 0));
        foreach (t[i]) begin
            apply(t[i]);
            @(negedge clk_i);
            if (t[i].we) begin
                exp_w = exp_q.pop_front();
                n_chk++; if (rf_we_o !== 1'b1 || {rf_addr_o, rf_data_o} !== exp_w) begin n_fail++; $display("FAIL x0_write[%0d]: got we=%b x%0d=%h expected x%0d=%h", i, rf_we_o, rf_addr_o, rf_data_o, exp_w[36:32], exp_w[31:0]); end
            end else begin
                n_chk++; if (rf_we_o !== 1'b0) begin n_fail++; $display("FAIL x0_we[%0d]: got %b expected 0", i, rf_we_o); end
            end
            n_chk++; if (pipe_stall_o !== t[i].st) begin n_fail++; $display("FAIL x0_stall[%0d]: got %b expected %b", i, pipe_stall_o, t[i].st); end
            n_chk++; if (pending_o !== 2'(t[i].pn)) begin n_fail++; $display("FAIL x0_pending[%0d]: got %0d expected %0d", i, pending_o, t[i].pn); end
            n_chk++; if (chk_hit_o !== t[i].ht) begin n_fail++; $display("FAIL x0_hit[%0d]: got %b expected %b", i, chk_hit_o, t[i].ht); end
        end
    endtask

    initial begin
        foreach (shadow[i]) shadow[i] = '0;
        test_reset();
        test_bypass();
        test_starvation();
        test_waw();
        test_full();
        test_x0();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d unmatched writes expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
